mmio_uart: RTL and testbench
============================

# mmio_uart

Memory-mapped UART responder on the MMIO port of the CPU memory mapper, window 0x0038_0000–0x0038_03FF. It decodes mapper-supplied offsets, holds TX bytes in a FIFO, and serializes them 8N1 on `out_uart_tx`. It also deserializes `in_uart_rx` into a single holding register. Reads have no side effects: software acknowledges received bytes by an explicit CONTROL write.

## Interface
- `TX_FIFO_DEPTH`, 8, TX FIFO entries; power of two, ≥2.
- `BAUD_DIV_RESET`, 16'd868, reset value of BAUD_DIV (868 = 100 MHz / 115200).

- `in_clk`  input  1  single clock for the whole block.
- `in_mmio_reset`  input  1  reset. One clock; reset is synchronous and active-high.
- `in_mmio_address`  input  32  byte offset inside the MMIO window. Decode uses [9:2]; [1:0] and [31:10] are ignored.
- `in_mmio_write_data`  input  32  write data.
- `in_mmio_write_en`  input  32  write strobe. Only bit 0 is used.
- `out_mmio_read_data`  output  32  combinational read data for the current address.
- `in_uart_rx`  input  1  asynchronous serial input, idle high.
- `out_uart_tx`  output  1  serial output, idle high. Registered.

## Operation
- Register map (byte offsets):
  - 0x000 TX_DATA
    - W: push [7:0] into the FIFO.
    - R: 0.
  - 0x004 RX_DATA
    - R: {23'b0, rx_valid, rx_byte[7:0]}.
    - Writes ignored.
  - 0x008 STATUS (R only)
    - bit0 tx_full, bit1 tx_empty, bit2 tx_busy.
    - bit3 rx_valid, bit4 rx_overrun, bit5 tx_dropped, bit6 rx_frame_err.
    - All other bits 0.
  - 0x00C CONTROL (W only)
    - bit0 rx_ack: clear rx_valid.
    - bit1: clear rx_overrun.
    - bit2: clear tx_dropped.
    - bit3: clear rx_frame_err.
    - Reads 0.
  - 0x010 BAUD_DIV
    - R/W, [15:0], clock cycles per bit.
    - A write of 0 stores 1.
  - Unmapped offsets read 0; writes to them are ignored.
- TX path:
  - A push while the FIFO is full is discarded and sets sticky tx_dropped.
  - TX FSM states: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - In IDLE with the FIFO non-empty, the FSM pops one byte and enters START.
  - BAUD_DIV is latched at frame start; a mid-frame BAUD_DIV write affects the next frame only.
  - tx_busy = FSM not in IDLE.
- RX path:
  - 2-flop synchronizer on `in_uart_rx`.
  - RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE→START on a synchronized falling edge.
  - START waits BAUD_DIV/2 cycles (integer division; minimum 1). If the line is high at that point, it is a false start → IDLE.
  - DATA samples 8 bits, one every BAUD_DIV cycles, LSB first.
  - STOP samples after BAUD_DIV cycles:
    - Line high and rx_valid=0: load rx_byte and set rx_valid.
    - Line high and rx_valid=1: keep the old byte and set rx_overrun.
    - Line low: set rx_frame_err and discard the byte.
- Simultaneous events:
  - rx_ack in the same cycle as a STOP load: the new byte loads, rx_valid stays 1, no overrun.
  - A clear bit and a set event in the same cycle: set wins.
  - Push and pop in the same cycle with the FIFO full: the push is accepted.
- Reset, including mid-frame:
  - Both FSMs go to IDLE and the FIFO empties.
  - `out_uart_tx`=1.
  - rx_valid, rx_byte and all sticky flags = 0.
  - BAUD_DIV = BAUD_DIV_RESET.
  - `out_mmio_read_data` follows the address: STATUS reads 0x0000_0002.

## Timing
- Reads are combinational, same cycle, to fit the single-cycle CPU load path.
- Writes take effect at the rising edge where `in_mmio_write_en[0]`=1.
- Push at edge E with the FSM idle: pop and `out_uart_tx`=0 at edge E+1.
- Frame length is 10×BAUD_DIV cycles. The next queued frame's start bit begins immediately after the stop bit (back-to-back, no gap).
- RX: a byte is visible in RX_DATA one edge after the STOP sample. That sample falls ≈9.5×BAUD_DIV+2 cycles after the start edge on the pin; the +2 is synchronizer latency.

## Structure
- Package `mmio_pkg`:
  - register offset constants.
  - STATUS/CONTROL bit indices.
  - TX and RX FSM state enums.
  - 8N1 frame constants.
- Sub-module `mmio_fifo`: synchronous FIFO with parameter DEPTH, 8-bit width, push/pop/full/empty. Pointers carry one extra wrap bit; it is reset by the same synchronous reset.
- TX FSM, RX FSM and register decode live in `mmio_uart`.

## Test plan
- Reset, then read 0x008 → 0x0000_0002. Read 0x010 → 0x0000_0364. `out_uart_tx`=1.
- BAUD_DIV=4; write 0x55 to 0x000 → tx low one cycle after the write edge. Line pattern 0,1,0,1,0,1,0,1,0,1, 4 cycles each. tx_busy clears after 40 cycles.
- Write 9 bytes back-to-back with TX_FIFO_DEPTH=8 and BAUD_DIV=4:
  - the first byte is popped at the next edge, so all 9 are accepted and none drops.
  - a 10th write sets tx_dropped.
  - all 9 frames appear back-to-back.
- Drive RX frame 0xA3 at BAUD_DIV=4 → RX_DATA reads 0x0000_01A3.
  - A second frame before ack → rx_overrun=1 and RX_DATA still 0x1A3.
  - CONTROL=0x3 → STATUS bits 3,4 clear.
- Glitch: RX low for 1 cycle → no byte, FSM back to IDLE. Frame with stop bit 0 → rx_frame_err=1, rx_valid=0.
- Assert reset mid-TX-frame with 3 bytes queued → tx=1 on the next edge, tx_empty=1, no further frames.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants, state enums and helpers for the memory-mapped UART.
package mmio_pkg;

  // Register word indices, decoded from address bits [9:2].
  localparam logic [7:0] RegTxData  = 8'h00;
  localparam logic [7:0] RegRxData  = 8'h01;
  localparam logic [7:0] RegStatus  = 8'h02;
  localparam logic [7:0] RegControl = 8'h03;
  localparam logic [7:0] RegBaudDiv = 8'h04;

  // STATUS bit positions.
  localparam int unsigned StatTxFull   = 0;
  localparam int unsigned StatTxEmpty  = 1;
  localparam int unsigned StatTxBusy   = 2;
  localparam int unsigned StatRxValid  = 3;
  localparam int unsigned StatRxOvr    = 4;
  localparam int unsigned StatTxDrop   = 5;
  localparam int unsigned StatFrameErr = 6;

  // CONTROL bit positions.
  localparam int unsigned CtrlRxAck      = 0;
  localparam int unsigned CtrlClrOverrun = 1;
  localparam int unsigned CtrlClrDropped = 2;
  localparam int unsigned CtrlClrFrame   = 3;

  // 8N1 framing.
  localparam int unsigned FrameDataBits = 8;
  localparam logic [2:0]  LastDataBit   = 3'(FrameDataBits - 1);
  localparam logic        LineIdle      = 1'b1;
  localparam logic        LineStart     = 1'b0;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Mid-bit offset for start-bit validation, never below one cycle.
  function automatic logic [15:0] half_div(input logic [15:0] div);
    logic [15:0] half;
    half = {1'b0, div[15:1]};
    return (half == 16'd0) ? 16'd1 : half;
  endfunction

  // A zero divisor would stall both FSMs, so it is stored as one.
  function automatic logic [15:0] sane_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous byte FIFO; pointers carry a wrap bit to tell full from empty.
module mmio_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]     mem_q [DEPTH];
  logic           do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AddrW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AddrW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart.sv
// MMIO UART: register decode, TX FIFO + 8N1 serializer, RX deserializer.
module mmio_uart
  import mmio_pkg::*;
#(
  parameter int unsigned TX_FIFO_DEPTH  = 8,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd868
) (
  input  logic        in_clk,
  input  logic        in_mmio_reset,
  input  logic [31:0] in_mmio_address,
  input  logic [31:0] in_mmio_write_data,
  input  logic [31:0] in_mmio_write_en,
  output logic [31:0] out_mmio_read_data,
  input  logic        in_uart_rx,
  output logic        out_uart_tx
);

  logic [7:0] reg_idx;
  logic       wr_en, wr_tx, wr_ctrl, wr_baud;
  logic       unused_bits;

  assign reg_idx = in_mmio_address[9:2];
  assign wr_en   = in_mmio_write_en[0];
  assign wr_tx   = wr_en && (reg_idx == RegTxData);
  assign wr_ctrl = wr_en && (reg_idx == RegControl);
  assign wr_baud = wr_en && (reg_idx == RegBaudDiv);
  assign unused_bits = ^{in_mmio_address[31:10], in_mmio_address[1:0],
                         in_mmio_write_en[31:1], in_mmio_write_data[31:16]};

  logic [15:0] baud_q;

  // TX state
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_line_q, tx_line_d, tx_bit_end;

  // RX state
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic        rx_line, rx_fall, rx_done;

  // Flags
  logic       rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic       tx_drop_q, tx_drop_d, rx_ferr_q, rx_ferr_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_ack, valid_eff, rx_load;

  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  mmio_fifo #(
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (in_clk),
    .rst_i   (in_mmio_reset),
    .push_i  (wr_tx),
    .wdata_i (in_mmio_write_data[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_bit_end  = (tx_cnt_q == tx_div_q - 16'd1);
  assign rx_line     = rx_sync2_q;
  assign rx_fall     = rx_prev_q && !rx_sync2_q;
  assign out_uart_tx = tx_line_q;

  // TX next state: pop and latch the divisor at every frame start, including back-to-back.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_line_d  = tx_line_q;
    fifo_pop   = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_line_d = LineIdle;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_state_d = TxStart;
          tx_shift_d = fifo_rdata;
          tx_div_d   = baud_q;
          tx_cnt_d   = '0;
          tx_line_d  = LineStart;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LastDataBit) begin
            tx_state_d = TxStop;
            tx_line_d  = LineIdle;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_state_d = TxStart;
            tx_shift_d = fifo_rdata;
            tx_div_d   = baud_q;
            tx_line_d  = LineStart;
          end else begin
            tx_state_d = TxIdle;
            tx_line_d  = LineIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // RX next state: validate start at mid-bit, then sample each bit one divisor apart.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
          rx_div_d   = baud_q;
        end
      end
      RxStart: begin
        if (rx_cnt_q == half_div(rx_div_q) - 16'd1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_line ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_bit_q == LastDataBit) rx_state_d = RxStop;
          else                         rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_done    = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Sticky flags: set wins over clear; an ack in the stop cycle frees the holding register.
  always_comb begin
    rx_ack    = wr_ctrl && in_mmio_write_data[CtrlRxAck];
    valid_eff = rx_valid_q && !rx_ack;
    rx_load   = rx_done && rx_line && !valid_eff;
    rx_valid_d = rx_load ? 1'b1 : (rx_ack ? 1'b0 : rx_valid_q);
    rx_byte_d  = rx_load ? rx_shift_q : rx_byte_q;
    rx_ovr_d   = (rx_done && rx_line && valid_eff) ||
                 (rx_ovr_q && !(wr_ctrl && in_mmio_write_data[CtrlClrOverrun]));
    rx_ferr_d  = (rx_done && !rx_line) ||
                 (rx_ferr_q && !(wr_ctrl && in_mmio_write_data[CtrlClrFrame]));
    tx_drop_d  = (wr_tx && fifo_full && !fifo_pop) ||
                 (tx_drop_q && !(wr_ctrl && in_mmio_write_data[CtrlClrDropped]));
  end

  // All state registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_mmio_reset) begin
      baud_q     <= BAUD_DIV_RESET;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= BAUD_DIV_RESET;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= LineIdle;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= BAUD_DIV_RESET;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_sync1_q <= LineIdle;
      rx_sync2_q <= LineIdle;
      rx_prev_q  <= LineIdle;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_drop_q  <= 1'b0;
    end else begin
      if (wr_baud) baud_q <= sane_div(in_mmio_write_data[15:0]);
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_sync1_q <= in_uart_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_drop_q  <= tx_drop_d;
    end
  end

  // Side-effect-free combinational read mux.
  always_comb begin
    out_mmio_read_data = '0;
    unique case (reg_idx)
      RegRxData: out_mmio_read_data = {23'b0, rx_valid_q, rx_byte_q};
      RegStatus: begin
        out_mmio_read_data[StatTxFull]   = fifo_full;
        out_mmio_read_data[StatTxEmpty]  = fifo_empty;
        out_mmio_read_data[StatTxBusy]   = (tx_state_q != TxIdle);
        out_mmio_read_data[StatRxValid]  = rx_valid_q;
        out_mmio_read_data[StatRxOvr]    = rx_ovr_q;
        out_mmio_read_data[StatTxDrop]   = tx_drop_q;
        out_mmio_read_data[StatFrameErr] = rx_ferr_q;
      end
      RegBaudDiv: out_mmio_read_data = {16'b0, baud_q};
      default:    out_mmio_read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed + randomized bench for mmio_uart against a frame-level reference model.
module tb_mmio_uart;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, wdata = '0, wen = '0, rdata;
  logic        rx = 1'b1, tx;

  int vectors = 0;
  int miscompares = 0;

  // Reference model of software-visible RX/TX flags.
  logic       m_valid = 0, m_ovr = 0, m_ferr = 0, m_drop = 0;
  logic [7:0] m_byte = '0;
  logic [7:0] tx_bytes [10];

  always #5 clk = ~clk;

  mmio_uart #(
    .TX_FIFO_DEPTH  (Depth),
    .BAUD_DIV_RESET (16'd868)
  ) dut (
    .in_clk             (clk),
    .in_mmio_reset      (rst),
    .in_mmio_address    (addr),
    .in_mmio_write_data (wdata),
    .in_mmio_write_en   (wen),
    .out_mmio_read_data (rdata),
    .in_uart_rx         (rx),
    .out_uart_tx        (tx)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    return {25'b0, m_ferr, m_drop, m_ovr, m_valid, 1'b0, 1'b1, 1'b0};
  endfunction

  // Ignored address/enable bits are randomized to exercise decode.
  function automatic logic [31:0] map_addr(input logic [31:0] a);
    logic [31:0] r;
    r = $urandom();
    return {r[31:10], a[9:2], r[1:0]};
  endfunction

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = $urandom();
    @(negedge clk);
    addr = map_addr(a); wdata = d; wen = {r[31:1], 1'b1};
    @(posedge clk);
    #1 wen = '0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = map_addr(a);
    #1 d = rdata;
  endtask

  // Expected line level k edges after the first push edge, n frames back to back.
  function automatic logic exp_tx(input int k, input int d, input int n);
    int t, f, slot;
    if (k < 1) return 1'b1;
    t = k - 1;
    f = t / (10 * d);
    if (f >= n) return 1'b1;
    slot = (t % (10 * d)) / d;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return tx_bytes[f][slot-1];
  endfunction

  task automatic tx_burst(input int nw, input int d, input logic [7:0] first);
    int nacc, bad, total;
    logic [31:0] st;
    bad = 0;
    for (int i = 0; i < 10; i++) tx_bytes[i] = (i == 0) ? first : 8'($urandom_range(0, 255));
    nacc = (nw > Depth + 1) ? Depth + 1 : nw;
    write_reg(32'h10, d);
    @(negedge clk);
    addr = 32'h0; wdata = {24'b0, tx_bytes[0]}; wen = 32'h1;
    for (int i = 1; i < nw; i++) begin
      @(negedge clk);
      if (tx !== exp_tx(i - 1, d, nacc)) bad++;
      wdata = {24'b0, tx_bytes[i]};
    end
    @(negedge clk);
    if (tx !== exp_tx(nw - 1, d, nacc)) bad++;
    wen = '0; addr = 32'h8;
    #1;
    check("tx_full", {31'b0, rdata[0]}, {31'b0, nw >= Depth + 1});
    check("tx_dropped", {31'b0, rdata[5]}, {31'b0, nw > Depth + 1});
    total = 10 * d * nacc + 2;
    for (int k = nw; k <= total; k++) begin
      @(negedge clk);
      if (tx !== exp_tx(k, d, nacc)) bad++;
      if (k == 10 * d * nacc)     check("tx_busy_last", {31'b0, rdata[2]}, 32'h1);
      if (k == 10 * d * nacc + 1) check("tx_busy_done", {31'b0, rdata[2]}, 32'h0);
    end
    check("tx_wave", bad, 0);
    if (nw > Depth + 1) m_drop = 1'b1;
    read_reg(32'h8, st);
    check("tx_status_after", st, status_exp());
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int d);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (d) @(negedge clk);
    end
    rx = 1'b1;
    repeat (d + 4) @(negedge clk);
    if (!stop)        m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_valid = 1'b1;
      m_byte  = b;
    end
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] r;
    read_reg(32'h4, r);
    check({tag, "_data"}, r, {23'b0, m_valid, m_byte});
    read_reg(32'h8, r);
    check({tag, "_status"}, r, status_exp());
  endtask

  initial begin
    logic [31:0] r;
    int d, lows;
    logic [3:0] ctrl;

    repeat (3) @(negedge clk);
    read_reg(32'h8, r);
    check("status_in_reset", r, 32'h2);
    @(negedge clk) rst = 1'b0;

    read_reg(32'h8, r);   check("status_reset", r, 32'h2);
    read_reg(32'h10, r);  check("baud_reset", r, 32'h364);
    check("tx_idle_reset", {31'b0, tx}, 32'h1);
    read_reg(32'h4, r);   check("rxdata_reset", r, 32'h0);
    read_reg(32'h0, r);   check("txdata_reads0", r, 32'h0);
    read_reg(32'hC, r);   check("control_reads0", r, 32'h0);
    read_reg(32'h3FC, r); check("unmapped_reads0", r, 32'h0);

    write_reg(32'h10, 32'h0);
    read_reg(32'h10, r);  check("baud_zero_is_one", r, 32'h1);
    @(negedge clk);
    addr = 32'h10; wdata = 32'h77; wen = 32'hFFFF_FFFE;
    @(negedge clk) wen = '0;
    read_reg(32'h10, r);  check("baud_en_bit0_only", r, 32'h1);
    write_reg(32'h3F0, 32'hFFFF_FFFF);
    read_reg(32'h8, r);   check("unmapped_write_ignored", r, 32'h2);

    tx_burst(1, 4, 8'h55);
    for (int i = 0; i < 3; i++)
      tx_burst(int'($urandom_range(1, 3)), int'($urandom_range(2, 6)), 8'($urandom_range(0, 255)));
    tx_burst(10, 4, 8'($urandom_range(0, 255)));
    write_reg(32'hC, 32'h4);
    m_drop = 1'b0;
    read_reg(32'h8, r);   check("drop_cleared", r, status_exp());

    write_reg(32'h10, 32'd4);
    rx_send(8'hA3, 1'b1, 4);
    check_rx("rx_a3");
    read_reg(32'h4, r);   check("rx_a3_literal", r, 32'h1A3);
    rx_send(8'($urandom_range(0, 255)), 1'b1, 4);
    check_rx("rx_overrun");
    write_reg(32'hC, 32'h3);
    m_valid = 1'b0; m_ovr = 1'b0;
    check_rx("rx_ack_clear");

    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (40) @(negedge clk);
    check_rx("rx_glitch");
    rx_send(8'($urandom_range(0, 255)), 1'b1, 4);
    check_rx("rx_after_glitch");
    write_reg(32'hC, 32'h1);
    m_valid = 1'b0;
    rx_send(8'($urandom_range(0, 255)), 1'b0, 4);
    check_rx("rx_frame_err");
    write_reg(32'hC, 32'h8);
    m_ferr = 1'b0;
    check_rx("rx_ferr_clear");

    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(3, 6));
      write_reg(32'h10, d);
      rx_send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), d);
      check_rx("rx_rand");
      ctrl = 4'($urandom_range(0, 15));
      write_reg(32'hC, {28'b0, ctrl});
      if (ctrl[0]) m_valid = 1'b0;
      if (ctrl[1]) m_ovr = 1'b0;
      if (ctrl[2]) m_drop = 1'b0;
      if (ctrl[3]) m_ferr = 1'b0;
      check_rx("rx_rand_ctrl");
    end

    // Reset mid-frame with three bytes still queued.
    write_reg(32'h10, 32'd4);
    if (!m_valid) rx_send(8'h3C, 1'b1, 4);
    @(negedge clk);
    addr = 32'h0; wen = 32'h1;
    for (int i = 0; i < 4; i++) begin
      wdata = 32'($urandom_range(0, 255));
      @(negedge clk);
    end
    wen = '0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("tx_high_on_reset", {31'b0, tx}, 32'h1);
    @(negedge clk) rst = 1'b0;
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_drop = 0; m_byte = '0;
    read_reg(32'h8, r);  check("status_after_reset", r, 32'h2);
    read_reg(32'h10, r); check("baud_after_reset", r, 32'h364);
    read_reg(32'h4, r);  check("rxdata_after_reset", r, 32'h0);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_frames_after_reset", lows, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
